// File: rtl/clock_ctrl.sv
// Run/stop/set sequencer for the mm:ss BCD clock: 1 Hz time base, button edge
// detection, BCD minute/second registers and blink qualifiers for the edited field.
module clock_ctrl #(
  parameter int TICK_DIV  = 50000000,
  parameter int BLINK_DIV = 25000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [7:0] sec,
  output logic [7:0] min,
  output logic [1:0] state,
  output logic       running,
  output logic       sec_tick,
  output logic       blank_min,
  output logic       blank_sec
);

  localparam logic [1:0] ST_RUN     = 2'b00;
  localparam logic [1:0] ST_STOP    = 2'b01;
  localparam logic [1:0] ST_SET_MIN = 2'b10;
  localparam logic [1:0] ST_SET_SEC = 2'b11;

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [PW-1:0] TICK_LAST  = PW'(TICK_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  logic [PW-1:0] prescaler;
  logic [BW-1:0] blink_cnt;
  logic          blink_phase;
  logic          mode_q;
  logic          inc_q;
  logic          mode_rise;
  logic          inc_rise;
  logic          tick;
  logic [8:0]    sec_next;
  logic [8:0]    min_next;

  // Returns {carry, next} for a packed-BCD value counting 00..59.
  function automatic logic [8:0] bcd_inc60(input logic [7:0] v);
    logic [8:0] r;
    if (v == 8'h59)
      r = 9'h100;
    else if (v[3:0] == 4'd9)
      r = {1'b0, v[7:4] + 4'd1, 4'd0};
    else
      r = {1'b0, v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

  assign mode_rise = btn_mode & ~mode_q;
  assign inc_rise  = btn_inc & ~inc_q;
  assign tick      = (state == ST_RUN) && (prescaler == TICK_LAST);
  assign sec_next  = bcd_inc60(sec);
  assign min_next  = bcd_inc60(min);

  assign running   = (state == ST_RUN);
  assign blank_min = (state == ST_SET_MIN) & blink_phase;
  assign blank_sec = (state == ST_SET_SEC) & blink_phase;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_RUN;
      sec         <= 8'h00;
      min         <= 8'h00;
      prescaler   <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      mode_q      <= 1'b0;
      inc_q       <= 1'b0;
      sec_tick    <= 1'b0;
    end else begin
      mode_q   <= btn_mode;
      inc_q    <= btn_inc;
      sec_tick <= tick;

      if (blink_cnt == BLINK_LAST) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + BW'(1);
      end

      // Holding the prescaler at zero outside RUN makes the first second after a restart full length.
      if (state == ST_RUN)
        prescaler <= tick ? '0 : prescaler + PW'(1);
      else
        prescaler <= '0;

      // The encoding is ordered so the mode cycle RUN->STOP->SET_MIN->SET_SEC->RUN is a 2-bit increment.
      if (mode_rise)
        state <= state + 2'd1;

      if (tick) begin
        sec <= sec_next[7:0];
        if (sec_next[8])
          min <= min_next[7:0];
      end else if (inc_rise && !mode_rise) begin
        case (state)
          ST_STOP: begin
            sec <= 8'h00;
            min <= 8'h00;
          end
          ST_SET_MIN: min <= min_next[7:0];
          ST_SET_SEC: sec <= sec_next[7:0];
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_clock_ctrl.sv
// Scoreboard bench for clock_ctrl: a minutes/seconds integer model queues the expected
// outputs for each clock edge and a separate monitor pops and compares them.
module tb_clock_ctrl;

  localparam int TICK_DIV  = 4;
  localparam int BLINK_DIV = 2;

  typedef struct packed {
    logic [7:0] sec;
    logic [7:0] min;
    logic [1:0] state;
    logic       running;
    logic       sec_tick;
    logic       blank_min;
    logic       blank_sec;
  } exp_t;

  logic       clk;
  logic       reset;
  logic       btn_mode;
  logic       btn_inc;
  logic [7:0] sec;
  logic [7:0] min;
  logic [1:0] state;
  logic       running;
  logic       sec_tick;
  logic       blank_min;
  logic       blank_sec;

  int total = 0;
  int bad   = 0;
  exp_t exp_q[$];

  int m_sec, m_min, m_st, m_pre, m_blink;
  bit m_phase, m_mode_prev, m_inc_prev;

  clock_ctrl #(.TICK_DIV(TICK_DIV), .BLINK_DIV(BLINK_DIV)) dut (
    .clk(clk), .reset(reset), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .sec(sec), .min(min), .state(state), .running(running),
    .sec_tick(sec_tick), .blank_min(blank_min), .blank_sec(blank_sec)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: bench did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [7:0] toBcd(input int v);
    return 8'(((v / 10) * 16) + (v % 10));
  endfunction

  task automatic modelReset();
    m_sec = 0; m_min = 0; m_st = 0; m_pre = 0; m_blink = 0;
    m_phase = 0; m_mode_prev = 0; m_inc_prev = 0;
  endtask

  // One clock edge of the behavioural model: time held as plain minute/second integers.
  task automatic modelStep(input bit m, input bit i, output exp_t e);
    bit mr, ir, tk;
    mr = m && !m_mode_prev;
    ir = i && !m_inc_prev;
    m_mode_prev = m;
    m_inc_prev  = i;
    tk = (m_st == 0) && (m_pre == TICK_DIV - 1);
    m_pre = (m_st == 0 && !tk) ? m_pre + 1 : 0;
    if (tk) begin
      m_sec++;
      if (m_sec == 60) begin
        m_sec = 0;
        m_min = (m_min + 1) % 60;
      end
    end else if (ir && !mr) begin
      if (m_st == 1) begin
        m_sec = 0;
        m_min = 0;
      end else if (m_st == 2) begin
        m_min = (m_min + 1) % 60;
      end else if (m_st == 3) begin
        m_sec = (m_sec + 1) % 60;
      end
    end
    if (mr) m_st = (m_st + 1) % 4;
    m_blink++;
    if (m_blink == BLINK_DIV) begin
      m_blink = 0;
      m_phase = !m_phase;
    end
    e.sec       = toBcd(m_sec);
    e.min       = toBcd(m_min);
    e.state     = 2'(m_st);
    e.running   = (m_st == 0);
    e.sec_tick  = tk;
    e.blank_min = (m_st == 2) && m_phase;
    e.blank_sec = (m_st == 3) && m_phase;
  endtask

  task automatic driveStep(input bit m, input bit i);
    exp_t e;
    btn_mode = m;
    btn_inc  = i;
    modelStep(m, i, e);
    exp_q.push_back(e);
  endtask

  task automatic applyStimulus(input bit m, input bit i, input int cycles);
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      driveStep(m, i);
    end
  endtask

  task automatic pulse(input bit m, input bit i);
    applyStimulus(m, i, 1);
    applyStimulus(0, 0, 1);
  endtask

  task automatic checkVal(input string name, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    exp_t a;
    a = '{sec, min, state, running, sec_tick, blank_min, blank_sec};
    total++;
    if (a !== e) begin
      bad++;
      $display("[TB] FAIL cycle @%0t: got sec=%h min=%h st=%b run=%b tick=%b bm=%b bs=%b expected sec=%h min=%h st=%b run=%b tick=%b bm=%b bs=%b",
               $time, a.sec, a.min, a.state, a.running, a.sec_tick, a.blank_min, a.blank_sec,
               e.sec, e.min, e.state, e.running, e.sec_tick, e.blank_min, e.blank_sec);
    end
  endtask

  task automatic checkResetState(input string tag);
    checkVal({tag, " sec"}, int'(sec), 0);
    checkVal({tag, " min"}, int'(min), 0);
    checkVal({tag, " state"}, int'(state), 0);
    checkVal({tag, " running"}, int'(running), 1);
    checkVal({tag, " sec_tick"}, int'(sec_tick), 0);
    checkVal({tag, " blank"}, int'({blank_min, blank_sec}), 0);
  endtask

  // Asserts reset between clock edges and checks the outputs clear before the next edge.
  task automatic asyncReset();
    @(negedge clk);
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    #2 reset = 1'b1;
    #1 checkResetState("async reset");
    @(negedge clk);
    reset = 1'b0;
    modelReset();
    driveStep(0, 0);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) checkOutput(exp_q.pop_front());
    end
  end

  initial begin
    bit rm, ri;
    reset = 1'b1;
    btn_mode = 1'b0;
    btn_inc = 1'b0;
    #2 checkResetState("power-on reset");
    @(negedge clk);
    reset = 1'b0;
    modelReset();
    driveStep(0, 0);

    applyStimulus(0, 0, 10);
    pulse(1, 0);
    applyStimulus(0, 0, 100);
    pulse(0, 1);
    pulse(1, 0);
    for (int k = 0; k < 59; k++) pulse(0, 1);
    pulse(1, 0);
    for (int k = 0; k < 58; k++) pulse(0, 1);
    pulse(1, 0);
    applyStimulus(0, 0, 12);

    pulse(1, 0);
    pulse(1, 0);
    for (int k = 0; k < 59; k++) pulse(0, 1);
    pulse(1, 1);
    pulse(0, 1);
    applyStimulus(1, 0, 10);
    applyStimulus(0, 0, 6);
    pulse(1, 0);
    pulse(1, 0);
    pulse(0, 1);
    pulse(1, 0);
    for (int k = 0; k < 30; k++) pulse(0, 1);
    applyStimulus(0, 0, 8);

    pulse(1, 0);
    pulse(0, 1);
    pulse(1, 0);
    pulse(1, 0);
    for (int k = 0; k < 17; k++) pulse(0, 1);
    asyncReset();
    applyStimulus(0, 0, 10);

    rm = 0;
    ri = 0;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 7) == 0) rm = !rm;
      if ($urandom_range(0, 3) == 0) ri = !ri;
      applyStimulus(rm, ri, 1);
      if ($urandom_range(0, 999) == 0) asyncReset();
    end

    applyStimulus(0, 0, 3);
    @(posedge clk);
    #2;
    checkVal("scoreboard drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
